instr_queue: RTL and testbench

- Decoupling buffer between the decode stage and backend rename/dispatch.
- Each cycle it accepts up to ENQ_WIDTH decoded uops in program order and presents up to DEQ_WIDTH oldest uops to the backend.
- Flushed on branch misprediction.
- Circular FIFO of packed uop words: head/tail pointers plus an occupancy counter, with in-order lane compaction on enqueue.

---
 rtl/instr_queue.sv | 117 +++++++++++
 tb/tb_instr_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Decode-to-backend instruction queue: circular FIFO of packed uops with in-order lane compaction.
// Optional INSTR_Q_STATS_EN adds stall-cycle and high-water-mark counters.
module instr_queue #(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 2,
    parameter int UOP_BITS  = 128,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int TAKE_W   = $clog2(DEQ_WIDTH + 1)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            flush_in,
    input  logic [ENQ_WIDTH-1:0]            enq_valid_in,
    input  logic [ENQ_WIDTH*UOP_BITS-1:0]   enq_uop_in,
    output logic                            enq_ready_out,
    output logic [DEQ_WIDTH-1:0]            deq_valid_out,
    output logic [DEQ_WIDTH*UOP_BITS-1:0]   deq_uop_out,
    input  logic [TAKE_W-1:0]               deq_take_in,
    output logic [CNT_W-1:0]                count_out,
    output logic                            empty_out,
    output logic                            full_out
`ifdef INSTR_Q_STATS_EN
    ,
    output logic [31:0]                     stall_cycles_out,
    output logic [CNT_W-1:0]                high_water_out
`endif
);

    logic [UOP_BITS-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     enq_k, take_eff;
    logic [PTR_W-1:0]     lane_slot [ENQ_WIDTH];
    logic                 enq_ready, enq_fire;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        enq_k = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            lane_slot[i] = tail_q + PTR_W'(enq_k);
            if (enq_valid_in[i]) enq_k = enq_k + 1'b1;
        end
    end

    // Ready uses pre-dequeue occupancy, so count can never exceed DEPTH.
    assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH);
    assign enq_fire  = enq_ready && (|enq_valid_in);
    assign take_eff  = (CNT_W'(deq_take_in) > count_q) ? count_q : CNT_W'(deq_take_in);

    always_comb begin
        head_d  = head_q + PTR_W'(take_eff);
        tail_d  = enq_fire ? tail_q + PTR_W'(enq_k) : tail_q;
        count_d = count_q + (enq_fire ? enq_k : '0) - take_eff;
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq_fire && !flush_in) begin
            for (int i = 0; i < ENQ_WIDTH; i++)
                if (enq_valid_in[i]) mem_q[lane_slot[i]] <= enq_uop_in[i*UOP_BITS +: UOP_BITS];
        end
    end

    for (genvar j = 0; j < DEQ_WIDTH; j++) begin : g_deq
        assign deq_valid_out[j]                       = CNT_W'(j) < count_q;
        assign deq_uop_out[j*UOP_BITS +: UOP_BITS]   = mem_q[head_q + PTR_W'(j)];
    end

    assign enq_ready_out = enq_ready;
    assign count_out     = count_q;
    assign empty_out     = (count_q == '0);
    assign full_out      = (count_q == CNT_W'(DEPTH));

`ifdef INSTR_Q_STATS_EN
    logic [31:0]      stall_q;
    logic [CNT_W-1:0] hw_q;

    // Neither counter is touched by flush; only reset clears them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stall_q <= '0;
            hw_q    <= '0;
        end else begin
            if ((|enq_valid_in) && !enq_ready && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
            if (count_d > hw_q) hw_q <= count_d;
        end
    end

    assign stall_cycles_out = stall_q;
    assign high_water_out   = hw_q;
`endif

`ifndef SYNTHESIS
    a_take_legal: assert property (@(posedge clk_in) disable iff (rst_in)
        CNT_W'(deq_take_in) <= count_q);
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios then randomized traffic vs. a queue-based model.
module tb_instr_queue;
    localparam int DEPTH = 16, EW = 4, DW = 2, UB = 128;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                clk_in = 1'b0, rst_in = 1'b1, flush_in = 1'b0;
    logic [EW-1:0]       enq_valid_in = '0;
    logic [EW*UB-1:0]    enq_uop_in = '0;
    logic                enq_ready_out;
    logic [DW-1:0]       deq_valid_out;
    logic [DW*UB-1:0]    deq_uop_out;
    logic [1:0]          deq_take_in = '0;
    logic [CNT_W-1:0]    count_out;
    logic                empty_out, full_out;
`ifdef INSTR_Q_STATS_EN
    logic [31:0]         stall_cycles_out;
    logic [CNT_W-1:0]    high_water_out;
`endif

    instr_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .UOP_BITS(UB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .enq_valid_in(enq_valid_in), .enq_uop_in(enq_uop_in), .enq_ready_out(enq_ready_out),
        .deq_valid_out(deq_valid_out), .deq_uop_out(deq_uop_out), .deq_take_in(deq_take_in),
        .count_out(count_out), .empty_out(empty_out), .full_out(full_out)
`ifdef INSTR_Q_STATS_EN
        , .stall_cycles_out(stall_cycles_out), .high_water_out(high_water_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference model: program-ordered list of stored uops plus stats.
    logic [UB-1:0] mq [$];
    int unsigned   m_stall = 0;
    int            m_hw = 0;
    int            checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [UB-1:0] obs, input logic [UB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [UB-1:0] rnd_uop();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_outputs();
        int sz = mq.size();
        chk("count", UB'(count_out), UB'(sz));
        chk("ready", UB'(enq_ready_out), UB'((DEPTH - sz) >= EW));
        chk("empty", UB'(empty_out), UB'(sz == 0));
        chk("full", UB'(full_out), UB'(sz == DEPTH));
        for (int j = 0; j < DW; j++) begin
            chk("deq_valid", UB'(deq_valid_out[j]), UB'(j < sz));
            if (j < sz) chk("deq_uop", deq_uop_out[j*UB +: UB], mq[j]);
        end
`ifdef INSTR_Q_STATS_EN
        chk("stall", UB'(stall_cycles_out), UB'(m_stall));
        chk("high_water", UB'(high_water_out), UB'(m_hw));
`endif
    endtask

    // Called at negedge: drive, check pre-edge state, clock, update model.
    task automatic step(input logic [EW-1:0] v, input int t, input logic f);
        logic [EW*UB-1:0] u;
        bit rdy;
        for (int i = 0; i < EW; i++) u[i*UB +: UB] = rnd_uop();
        enq_valid_in = v; enq_uop_in = u; deq_take_in = 2'(t); flush_in = f;
        #1;
        check_outputs();
        rdy = (DEPTH - mq.size()) >= EW;
        @(posedge clk_in);
        if ((|v) && !rdy) m_stall++;
        if (f) mq.delete();
        else begin
            for (int k = 0; k < t; k++) void'(mq.pop_front());
            if (rdy) for (int i = 0; i < EW; i++) if (v[i]) mq.push_back(u[i*UB +: UB]);
        end
        if (mq.size() > m_hw) m_hw = mq.size();
        @(negedge clk_in);
        enq_valid_in = '0; deq_take_in = '0; flush_in = 1'b0;
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic do_reset();
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_count", UB'(count_out), '0);
        chk("async_rst_empty", UB'(empty_out), UB'(1));
        mq.delete(); m_stall = 0; m_hw = 0;
        @(posedge clk_in); @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        int t, sz;
        logic [EW-1:0] v;
        @(negedge clk_in);
        check_outputs();              // reset state while rst_in held
        rst_in = 1'b0;

        // Full group, then sparse group
        step(4'b1111, 0, 0);
        step(4'b0000, 0, 0);
        do_reset();
        step(4'b1010, 0, 0);
        step(4'b0000, 1, 0);
        step(4'b0000, 1, 0);

        // Ready boundary at count 13 with a same-cycle dequeue
        do_reset();
        step(4'b1111, 0, 0); step(4'b1111, 0, 0); step(4'b1111, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b1111, 2, 0);
        step(4'b1111, 1, 0);
        step(4'b0000, 0, 0);

        // Wrap across DEPTH-1 -> 0
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(4'b0001, 0, 0);
            step(4'b0000, 1, 0);
        end
        step(4'b1111, 0, 0);
        step(4'b0000, 2, 0);
        step(4'b0000, 2, 0);
        step(4'b0000, 0, 0);

        // Flush with simultaneous enqueue and dequeue at count 9
        do_reset();
        step(4'b1111, 0, 0); step(4'b1111, 0, 0); step(4'b0001, 0, 0);
        step(4'b1111, 2, 1);
        step(4'b0000, 0, 0);

        // Blocked while full, then flush keeps stats
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b1111, 0, 0);
        for (int i = 0; i < 3; i++) step(4'b1111, 0, 0);
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sz = mq.size();
            t = $urandom_range(0, (sz < DW) ? sz : DW);
            v = 4'($urandom);
            step(v, t, ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
